// File: rtl/vend_pkg.sv
// Shared types and constants for the vending I/O front end: coin indices,
// widths, 7-segment code table and the binary->BCD helper.
package vend_pkg;

  localparam int unsigned MONEY_W  = 12;
  localparam int unsigned NUM_KEYS = 3;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BCD_W    = 16;

  localparam int unsigned K_5J = 0;
  localparam int unsigned K_1Y = 1;
  localparam int unsigned K_5Y = 2;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_CODE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Segment pattern for one BCD digit; non-decimal codes render blank.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] digit);
    return (digit > 4'd9) ? SEG_BLANK : SEG_CODE[digit];
  endfunction

  // Double-dabble: 12-bit binary to four packed BCD digits {d3,d2,d1,d0}.
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [MONEY_W-1:0] bin);
    logic [BCD_W+MONEY_W-1:0] sr;
    sr = {BCD_W'(0), bin};
    for (int i = 0; i < int'(MONEY_W); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[MONEY_W + 4*d +: 4] >= 4'd5)
          sr[MONEY_W + 4*d +: 4] = sr[MONEY_W + 4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    return sr[BCD_W+MONEY_W-1:MONEY_W];
  endfunction

endpackage

// File: rtl/vend_io_frontend_if.sv
// Pin-side bundle of the vending I/O front end: raw keys and credit in,
// debounced key levels/pulses and 7-segment scan drive out.
interface vend_io_frontend_if;
  import vend_pkg::*;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_fall;
  logic [MONEY_W-1:0]  value;
  logic [IDX_W-1:0]    which_seg;
  logic [SEG_W-1:0]    seg;

  modport master (
    output key_in, value,
    input  key_db, key_rise, key_fall, which_seg, seg
  );

  modport slave (
    input  key_in, value,
    output key_db, key_rise, key_fall, which_seg, seg
  );
endinterface

// File: rtl/key_debounce.sv
// One-key synchronizer and debouncer: key_db follows the synced key only after
// it has differed for DB_CYCLES consecutive cycles; edges give 1-cycle pulses.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_db,
  output logic key_rise,
  output logic key_fall
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_s;
  logic             terminal;

  assign key_s    = sync_q[1];
  assign terminal = (cnt_q == CNT_W'(DB_CYCLES - 1));

  // Any cycle where the synced key agrees with key_db restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      key_db   <= 1'b0;
      key_rise <= 1'b0;
      key_fall <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_in};
      key_rise <= 1'b0;
      key_fall <= 1'b0;
      if (key_s == key_db) begin
        cnt_q <= '0;
      end else if (terminal) begin
        cnt_q    <= '0;
        key_db   <= key_s;
        key_rise <= key_s;
        key_fall <= ~key_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_io_frontend.sv
// Vending-machine I/O front end: three debounced coin keys and a multiplexed
// 4-digit 7-segment display of the 12-bit credit value.
module vend_io_frontend
  import vend_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned SCAN_CYCLES = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  vend_io_frontend_if.slave bus
);

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .key_in   (bus.key_in[k]),
      .key_db   (bus.key_db[k]),
      .key_rise (bus.key_rise[k]),
      .key_fall (bus.key_fall[k])
    );
  end

  logic [MONEY_W-1:0] value_q;
  logic [SCAN_W-1:0]  scan_q, scan_nxt;
  logic [1:0]         idx_q, idx_nxt;
  logic [SEG_W-1:0]   seg_q, seg_nxt;
  logic               load_q;
  logic               wrap;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         d0, d1, d2, d3;
  logic [SEG_W-1:0]   code;

  assign bcd            = bin2bcd(value_q);
  assign {d3, d2, d1, d0} = bcd;
  assign wrap           = (scan_q == SCAN_W'(SCAN_CYCLES - 1));

  // seg is latched only when a slot starts, so a digit never tears mid-slot.
  always_comb begin
    scan_nxt = wrap ? '0 : scan_q + SCAN_W'(1);
    idx_nxt  = wrap ? idx_q + 2'd1 : idx_q;
    seg_nxt  = seg_q;
    code     = SEG_BLANK;
    case (idx_nxt)
      2'd0:    code = seg_of(d0);
      2'd1:    code = seg_of(d1);
      2'd2:    code = (d3 == 4'd0 && d2 == 4'd0) ? SEG_BLANK : seg_of(d2);
      default: code = (d3 == 4'd0) ? SEG_BLANK : seg_of(d3);
    endcase
    if (wrap || load_q)
      seg_nxt = code;
  end

  // load_q refills the blanked segment right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      seg_q   <= SEG_BLANK;
      load_q  <= 1'b1;
    end else begin
      value_q <= bus.value;
      scan_q  <= scan_nxt;
      idx_q   <= idx_nxt;
      seg_q   <= seg_nxt;
      load_q  <= 1'b0;
    end
  end

  assign bus.which_seg = IDX_W'(idx_q);
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_vend_io_frontend.sv
// Directed bench for vend_io_frontend with DB_CYCLES=4, SCAN_CYCLES=3.
module tb_vend_io_frontend;
  import vend_pkg::*;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  vend_io_frontend_if bus ();

  vend_io_frontend #(.DB_CYCLES(4), .SCAN_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.key_in = 3'b000;
    bus.value = 12'd0;
    step();
    step();
    total++;
    if ({bus.key_db, bus.key_rise, bus.key_fall} !== 9'd0 ||
        bus.which_seg !== 3'd0 || bus.seg !== 7'h00)
      $display("FAIL reset: db=%b rise=%b fall=%b which=%0d seg=%h, need all 0",
               bus.key_db, bus.key_rise, bus.key_fall, bus.which_seg, bus.seg);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    bus.key_in[K_5J] = 1'b1;
    step(); step(); step();
    bus.key_in[K_5J] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      total++;
      if (bus.key_db !== 3'b000 || bus.key_rise !== 3'b000 || bus.key_fall !== 3'b000)
        $display("FAIL glitch cyc%0d: db=%b rise=%b fall=%b, need 000", n,
                 bus.key_db, bus.key_rise, bus.key_fall);
      else passed++;
    end
  endtask

  task automatic test_press_release();
    bus.key_in[K_1Y] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      total++;
      if (bus.key_db[K_1Y] !== (n >= 6) || bus.key_rise[K_1Y] !== (n == 6) ||
          bus.key_fall[K_1Y] !== 1'b0)
        $display("FAIL press cyc%0d: db=%b rise=%b fall=%b, need db=%0d rise=%0d fall=0",
                 n, bus.key_db[K_1Y], bus.key_rise[K_1Y], bus.key_fall[K_1Y],
                 n >= 6, n == 6);
      else passed++;
    end
    bus.key_in[K_1Y] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      total++;
      if (bus.key_db[K_1Y] !== (n < 6) || bus.key_fall[K_1Y] !== (n == 6) ||
          bus.key_rise[K_1Y] !== 1'b0)
        $display("FAIL release cyc%0d: db=%b fall=%b rise=%b, need db=%0d fall=%0d rise=0",
                 n, bus.key_db[K_1Y], bus.key_fall[K_1Y], bus.key_rise[K_1Y],
                 n < 6, n == 6);
      else passed++;
    end
  endtask

  // Checks seg against exp[which_seg], step order 0->1->2->3->0, 3 cycles per slot.
  task automatic check_display(input string name, input logic [11:0] val,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp [4];
    int         seen [4];
    logic [2:0] prev;
    exp = '{e0, e1, e2, e3};
    seen = '{0, 0, 0, 0};
    bus.value = val;
    for (int n = 0; n < 26; n++) step();
    prev = bus.which_seg;
    for (int n = 0; n < 12; n++) begin
      total++;
      if (bus.which_seg > 3'd3)
        $display("FAIL %s which_seg: got %0d, need 0..3", name, bus.which_seg);
      else if (bus.seg !== exp[bus.which_seg[1:0]])
        $display("FAIL %s digit%0d: seg=%h, need %h", name, bus.which_seg,
                 bus.seg, exp[bus.which_seg[1:0]]);
      else if (n > 0 && bus.which_seg != prev && bus.which_seg[1:0] != prev[1:0] + 2'd1)
        $display("FAIL %s order: %0d after %0d", name, bus.which_seg, prev);
      else passed++;
      if (bus.which_seg <= 3'd3) seen[bus.which_seg[1:0]]++;
      prev = bus.which_seg;
      step();
    end
    total++;
    if (seen[0] != 3 || seen[1] != 3 || seen[2] != 3 || seen[3] != 3)
      $display("FAIL %s slot_len: %0d/%0d/%0d/%0d, need 3/3/3/3", name,
               seen[0], seen[1], seen[2], seen[3]);
    else passed++;
  endtask

  task automatic test_display();
    check_display("v1234", 12'd1234, 7'h66, 7'h4F, 7'h5B, 7'h06);
    check_display("v5",    12'd5,    7'h6D, 7'h3F, 7'h00, 7'h00);
    check_display("v4095", 12'd4095, 7'h6D, 7'h6F, 7'h3F, 7'h66);
    check_display("v207",  12'd207,  7'h07, 7'h3F, 7'h5B, 7'h00);
  endtask

  task automatic test_back_to_back();
    bus.key_in = 3'b111;
    for (int n = 1; n <= 7; n++) begin
      step();
      total++;
      if (bus.key_rise !== ((n == 6) ? 3'b111 : 3'b000) ||
          bus.key_db !== ((n >= 6) ? 3'b111 : 3'b000) || bus.key_fall !== 3'b000)
        $display("FAIL all_press cyc%0d: db=%b rise=%b fall=%b", n,
                 bus.key_db, bus.key_rise, bus.key_fall);
      else passed++;
    end
    bus.key_in = 3'b000;
    for (int n = 1; n <= 7; n++) begin
      step();
      total++;
      if (bus.key_fall !== ((n == 6) ? 3'b111 : 3'b000) ||
          bus.key_db !== ((n < 6) ? 3'b111 : 3'b000) || bus.key_rise !== 3'b000)
        $display("FAIL all_release cyc%0d: db=%b rise=%b fall=%b", n,
                 bus.key_db, bus.key_rise, bus.key_fall);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    bus.value = 12'd1234;
    bus.key_in = 3'b101;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    total++;
    if ({bus.key_db, bus.key_rise, bus.key_fall} !== 9'd0 ||
        bus.which_seg !== 3'd0 || bus.seg !== 7'h00)
      $display("FAIL mid_reset: db=%b rise=%b fall=%b which=%0d seg=%h, need all 0",
               bus.key_db, bus.key_rise, bus.key_fall, bus.which_seg, bus.seg);
    else passed++;
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      total++;
      if (bus.key_db !== ((n >= 6) ? 3'b101 : 3'b000) ||
          bus.key_rise !== ((n == 6) ? 3'b101 : 3'b000))
        $display("FAIL post_reset cyc%0d: db=%b rise=%b", n, bus.key_db, bus.key_rise);
      else passed++;
    end
    check_display("after_reset", 12'd1234, 7'h66, 7'h4F, 7'h5B, 7'h06);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_glitch();
    test_press_release();
    test_display();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
